// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller
// Description : Stall / flush / forwarding sequencer for the 5-stage CPU.
//               Tracks EX/MEM/WB control metadata in a shadow pipeline and
//               derives the PC/IF_ID hold, IF_ID flush, EX operand forward
//               selects and the flag bypass, plus saturating event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rn,
    input  logic [REG_W-1:0]  id_rm,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_regwrite,
    input  logic              id_memtoreg,
    input  logic              id_flagwrite,
    input  logic              id_br_uses_reg,
    input  logic              id_br_uses_flags,
    input  logic              br_taken,
    output logic              stall,
    output logic              flush_ifid,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              flag_fwd,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [REG_W-1:0] c_zero_reg = REG_W'(ZERO_REG);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    // Control metadata carried alongside each pipeline register
    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic             memtoreg;
        logic             flagwrite;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] rm;
        logic             use_rn;
        logic             use_rm;
    } stage_t;

    stage_t r_ex;
    stage_t r_mem;
    stage_t r_wb;
    stage_t w_id_stage;

    logic w_load_use;
    logic w_cbz_ex;
    logic w_cbz_mem;
    logic w_stall;

    // A stage writes register r that is architecturally visible (XZR never counts)
    function automatic logic produces(input stage_t s, input logic [REG_W-1:0] r);
        return s.valid && s.regwrite && (s.rd == r) && (r != c_zero_reg);
    endfunction

    // Newest producer wins: EX_MEM result beats MEM_WR writeback data
    function automatic logic [1:0] fwd_sel(input stage_t mem_s, input stage_t wb_s,
                                           input logic [REG_W-1:0] src,
                                           input logic use_src);
        if (produces(mem_s, src) && use_src) begin
            return 2'b01;
        end else if (produces(wb_s, src)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    // Package the ID instruction as it would enter EX
    always_comb begin
        w_id_stage           = '0;
        w_id_stage.valid     = 1'b1;
        w_id_stage.regwrite  = id_regwrite;
        w_id_stage.memtoreg  = id_memtoreg;
        w_id_stage.flagwrite = id_flagwrite;
        w_id_stage.rd        = id_rd;
        w_id_stage.rn        = id_rn;
        w_id_stage.rm        = id_rm;
        w_id_stage.use_rn    = id_use_rn;
        w_id_stage.use_rm    = id_use_rm;
    end

    // Hazard detection: load-use, and CBZ operands not yet readable in ID
    always_comb begin
        w_load_use = id_valid && r_ex.memtoreg &&
                     ((produces(r_ex, id_rn) && id_use_rn) ||
                      (produces(r_ex, id_rm) && id_use_rm));
        // Any EX producer is too late for a compare done in ID
        w_cbz_ex   = id_valid && id_br_uses_reg && produces(r_ex, id_rm);
        // A load in MEM has no data until WB, so the branch waits one more cycle
        w_cbz_mem  = id_valid && id_br_uses_reg && r_mem.memtoreg &&
                     produces(r_mem, id_rm);
        w_stall    = w_load_use || w_cbz_ex || w_cbz_mem;
    end

    // Outputs; a stalled branch resolved on stale operands must not flush
    always_comb begin
        stall      = w_stall;
        flush_ifid = br_taken && id_valid && !w_stall;
        fwd_a      = fwd_sel(r_mem, r_wb, r_ex.rn, r_ex.use_rn);
        fwd_b      = fwd_sel(r_mem, r_wb, r_ex.rm, r_ex.use_rm);
        flag_fwd   = id_valid && id_br_uses_flags && r_ex.valid && r_ex.flagwrite;
    end

    // Shadow pipeline advances with ID_EX/EX_MEM/MEM_WR; a stall inserts a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (id_valid && !w_stall) begin
                r_ex <= w_id_stage;
            end else begin
                r_ex <= '0;
            end
        end
    end

    // Saturating stall / flush event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != c_cnt_max)) begin
                stall_count <= stall_count + c_cnt_one;
            end
            if (flush_ifid && (flush_count != c_cnt_max)) begin
                flush_count <= flush_count + c_cnt_one;
            end
        end
    end

    // Fields kept for debug visibility but not needed by later-stage decisions
    logic w_unused;
    assign w_unused = ^{r_mem.flagwrite, r_mem.rn, r_mem.rm, r_mem.use_rn, r_mem.use_rm,
                        r_wb.memtoreg, r_wb.flagwrite, r_wb.rn, r_wb.rm,
                        r_wb.use_rn, r_wb.use_rm};

endmodule
`default_nettype wire

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central stall/flush/forwarding sequencer for the 5-stage pipelined CPU (IF, ID, EX, MEM, WB).
- Keeps its own shadow pipeline of per-stage control metadata for EX, MEM and WB, advanced in lockstep with the ID_EX, EX_MEM and MEM_WR registers.
- Drives the PC/IF_ID hold, the ID_EX bubble, the IF_ID flush, the EX operand forwarding muxes and the flag bypass.
- Also keeps saturating stall and flush performance counters.

Parameters:
- REG_W, 5, register-index width.
- ZERO_REG, 31, index of XZR: never a producer or consumer for hazards or forwarding.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock (rising edge).
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rn  in  REG_W  first source register of ID instruction.
- id_rm  in  REG_W  second source register (already Reg2Loc-selected).
- id_use_rn  in  1  ID instruction reads id_rn in EX.
- id_use_rm  in  1  ID instruction reads id_rm in EX.
- id_rd  in  REG_W  destination register.
- id_regwrite  in  1  ID instruction writes id_rd.
- id_memtoreg  in  1  ID instruction is a load.
- id_flagwrite  in  1  ID instruction sets NZCV.
- id_br_uses_reg  in  1  CBZ-type branch reading id_rm in ID.
- id_br_uses_flags  in  1  B.cond reading flags in ID.
- br_taken  in  1  branch resolved taken in ID this cycle.
- stall  out  1  hold PC and IF_ID; ID_EX loads bubble.
- flush_ifid  out  1  IF_ID loads a NOP next edge.
- fwd_a  out  2  EX operand A select.
- fwd_b  out  2  EX operand B select.
- flag_fwd  out  1  B.cond in ID uses live ALU flags instead of flag registers.
- stall_count  out  CNT_W  cycles with stall=1.
- flush_count  out  CNT_W  cycles with flush_ifid=1.

Behaviour:
- Shadow state per stage S in {EX, MEM, WB}: valid, regwrite, memtoreg, flagwrite, rd, rn, rm, use_rn, use_rm.
- A stage "produces r" when valid & regwrite & rd==r & r!=ZERO_REG.
- Reset (reset=0, asynchronous): all shadow valid=0. Counters=0. Hence stall=0, flush_ifid=0, fwd_a=fwd_b=0, flag_fwd=0. Reset asserted mid-stall or mid-flush drops it at once.
- Each rising edge:
  - WB<=MEM; MEM<=EX.
  - EX<=ID fields with valid=id_valid&~stall. A bubble carries valid=0.
- Register file writes on the falling edge, so a WB producer is visible to ID reads in the same cycle. No WB-to-ID forwarding is needed.
- stall (combinational), asserted if any of:
  - (a) Load-use: EX is a load producing id_rn with id_use_rn, or producing id_rm with id_use_rm.
  - (b) CBZ operand: id_br_uses_reg and EX produces id_rm (any type).
  - (c) CBZ operand: id_br_uses_reg and MEM is a load producing id_rm.
  - All terms are qualified by id_valid.
  - Resulting stall lengths: load then CBZ = 2 cycles; ALU op then CBZ = 1 cycle; load then use = 1 cycle.
- flush_ifid = br_taken & id_valid & ~stall. Stall has priority: BrTaken computed from stale operands is ignored.
- fwd_a (fwd_b identical on rm/use_rm), computed for the EX shadow instruction:
  - 2'b01 if MEM produces EX.rn and EX.use_rn (ALU result from EX_MEM).
  - Else 2'b10 if WB produces EX.rn (writeback data from MEM_WR).
  - Else 2'b00.
  - Newest producer wins. 2'b11 is never driven.
- flag_fwd = id_valid & id_br_uses_flags & EX.valid & EX.flagwrite.
- Counters: +1 per cycle of stall / flush_ifid respectively. They saturate at all-ones and never wrap.
- The ID instruction during a stall is re-evaluated every cycle. Its inputs must hold stable; that is the IF_ID hold's job.

Test Plan:
- Release reset, issue ADD X1,X2,X3 then SUB X4,X1,X5 -> no stall; when SUB is in EX, fwd_a=01. A third-cycle consumer of X1 gets fwd_a=10.
- LDUR X1,[X2] then ADD X3,X1,X4 -> stall=1 for exactly 1 cycle; ADD then in EX with fwd_b=00, fwd_a=10; stall_count=1.
- LDUR X9 then CBZ X9 -> stall high 2 consecutive cycles; ADDS X9 then CBZ X9 -> stall 1 cycle; stall_count=3 total.
- Producer to X31 (ADD XZR,...) followed by a reader of X31 -> no stall, fwd_a=fwd_b=00.
- SUBS in EX while B.EQ in ID with br_taken=1 -> flag_fwd=1, flush_ifid=1 same cycle, flush_count=1. Repeat with a load-use stall present -> flush_ifid=0 until stall clears.
- Pull reset low asynchronously (off clock edge) during the 2-cycle CBZ stall -> stall, fwd_*, flag_fwd and counters read 0 immediately.
